// File: rtl/hex_display_driver.sv
// -----------------------------------------------------------------------------
// hex_display_driver
//   Fabric-side consumer of the HPS seven-segment PIO words. It latches six digit
//   bytes, decodes them to active-low segment pins HEX0..HEX5, and adds per-digit
//   blank and blink. With HEX_DIMMER_EN defined, a PWM dimmer gates the lit segments.
//
//   Byte format: bit7 = RAW. RAW=1 -> bits[6:0] are an active-high segment pattern.
//                RAW=0 -> bit5 BLANK, bit4 BLINK, bits[3:0] hex glyph (bit6 ignored).
//
// Optional feature macro: HEX_DIMMER_EN (adds dim_level port and PWM counter).
//
// Ports
//   clk_clk       in   1         clock, rising edge
//   reset_reset   in   1         asynchronous reset, active-high
//   hex30_export  in   32        digit bytes 3..0 (byte k -> HEXk)
//   hex54_export  in   16        digit bytes 5..4
//   hold          in   1         1 = freeze capture
//   dim_level     in   PWM_BITS  brightness, 0 = dimmest (HEX_DIMMER_EN only)
//   hex0..hex5    out  7         segments {g,f,e,d,c,b,a}, active-low
//   update_o      out  1         one-cycle pulse when new digits reach the pins
// -----------------------------------------------------------------------------
module hex_display_driver #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned BLINK_HZ = 2,
   parameter int unsigned PWM_BITS = 3
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [31:0]         hex30_export,
   input  logic [15:0]         hex54_export,
   input  logic                hold,
`ifdef HEX_DIMMER_EN
   input  logic [PWM_BITS-1:0] dim_level,
`endif
   output logic [6:0]          hex0,
   output logic [6:0]          hex1,
   output logic [6:0]          hex2,
   output logic [6:0]          hex3,
   output logic [6:0]          hex4,
   output logic [6:0]          hex5,
   output logic                update_o
);

   localparam int unsigned HP    = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned CNT_W = $clog2(HP + 1);
   localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HP - 1);

   if (PWM_BITS == 0 || BLINK_HZ == 0 || HP == 0) begin : g_param_check
      $error("hex_display_driver: invalid PWM_BITS/BLINK_HZ/CLK_HZ combination");
   end

   // Returns the active-low pin value for one digit byte at the given blink phase.
   function automatic logic [6:0] f_decode(input logic [7:0] i_byte, input logic i_phase);
      logic [6:0] w_glyph;
      logic [6:0] w_pin;
      unique case (i_byte[3:0])
         4'h0:    w_glyph = 7'h3F;
         4'h1:    w_glyph = 7'h06;
         4'h2:    w_glyph = 7'h5B;
         4'h3:    w_glyph = 7'h4F;
         4'h4:    w_glyph = 7'h66;
         4'h5:    w_glyph = 7'h6D;
         4'h6:    w_glyph = 7'h7D;
         4'h7:    w_glyph = 7'h07;
         4'h8:    w_glyph = 7'h7F;
         4'h9:    w_glyph = 7'h6F;
         4'hA:    w_glyph = 7'h77;
         4'hB:    w_glyph = 7'h7C;
         4'hC:    w_glyph = 7'h39;
         4'hD:    w_glyph = 7'h5E;
         4'hE:    w_glyph = 7'h79;
         default: w_glyph = 7'h71;
      endcase
      if (i_byte[7]) begin
         w_pin = ~i_byte[6:0];
      end else if (i_byte[5] || (i_byte[4] && !i_phase)) begin
         w_pin = 7'h7F;
      end else begin
         w_pin = ~w_glyph;
      end
      return w_pin;
   endfunction

   logic [47:0]      r_cap;
   logic [47:0]      r_prev;
   logic [6:0]       r_hex [6];
   logic             r_update;
   logic [CNT_W-1:0] r_blink_cnt;
   logic             r_phase;
   // Set by the first update; until then the pins stay dark even if digits read as zero.
   logic             r_loaded;

   logic             w_update;
   logic [47:0]      w_digits;
   logic [CNT_W-1:0] w_blink_cnt_d;
   logic             w_phase_d;
   logic             w_dim_on;
   logic [6:0]       w_hex_d [6];

`ifdef HEX_DIMMER_EN
   logic [PWM_BITS-1:0] r_pwm;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= r_pwm + PWM_BITS'(1);
      end
   end

   assign w_dim_on = (r_pwm <= dim_level);
`else
   assign w_dim_on = 1'b1;
`endif

   always_comb begin
      w_update = (r_cap != r_prev);
      w_digits = w_update ? r_cap : r_prev;

      // An update restarts the blink cycle visible and overrides a coincident wrap.
      if (w_update) begin
         w_blink_cnt_d = '0;
         w_phase_d     = 1'b1;
      end else if (r_blink_cnt == HP_LAST) begin
         w_blink_cnt_d = '0;
         w_phase_d     = ~r_phase;
      end else begin
         w_blink_cnt_d = r_blink_cnt + CNT_W'(1);
         w_phase_d     = r_phase;
      end

      for (int k = 0; k < 6; k++) begin
         w_hex_d[k] = r_hex[k];
         if (w_update || r_loaded) begin
            w_hex_d[k] = w_dim_on ? f_decode(w_digits[8*k +: 8], w_phase_d) : 7'h7F;
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_cap       <= '0;
         r_prev      <= '0;
         r_update    <= 1'b0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
         r_loaded    <= 1'b0;
         for (int k = 0; k < 6; k++) begin
            r_hex[k] <= 7'h7F;
         end
      end else begin
         if (!hold) begin
            r_cap <= {hex54_export, hex30_export};
         end
         if (w_update) begin
            r_prev <= r_cap;
         end
         r_update    <= w_update;
         r_blink_cnt <= w_blink_cnt_d;
         r_phase     <= w_phase_d;
         r_loaded    <= r_loaded | w_update;
         for (int k = 0; k < 6; k++) begin
            r_hex[k] <= w_hex_d[k];
         end
      end
   end

   assign hex0     = r_hex[0];
   assign hex1     = r_hex[1];
   assign hex2     = r_hex[2];
   assign hex3     = r_hex[3];
   assign hex4     = r_hex[4];
   assign hex5     = r_hex[5];
   assign update_o = r_update;

endmodule
